// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - Start/Ack run controller sequencing three test programs
// Optional per-program RUN cycle counter enabled by PROGRAM_SEQUENCER_CYCLE_COUNT_EN.
module program_sequencer #(
    parameter int PC_W    = 10,
    parameter int P1_ADDR = 0,
    parameter int P2_ADDR = 256,
    parameter int P3_ADDR = 512,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcTarget,
    output logic             CoreEn,
    output logic             Ack,
    output logic [1:0]       ProgIdx,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [PC_W-1:0] P1_TARGET = PC_W'(P1_ADDR);
    localparam logic [PC_W-1:0] P2_TARGET = PC_W'(P2_ADDR);
    localparam logic [PC_W-1:0] P3_TARGET = PC_W'(P3_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] idx_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            ProgIdx <= 2'd0;
        end else begin
            state   <= state_next;
            ProgIdx <= idx_next;
        end
    end

    // Outputs decode only from registered state; inputs steer next state alone.
    always_comb begin
        state_next = state;
        idx_next   = ProgIdx;
        PcLoad     = 1'b0;
        CoreEn     = 1'b0;
        Ack        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start) state_next = S_ARMED;
            end
            S_ARMED: begin
                PcLoad = 1'b1;
                if (!Start) state_next = S_RUN;
            end
            S_RUN: begin
                CoreEn = 1'b1;
                if (Halt) state_next = S_DONE;
            end
            S_DONE: begin
                Ack = 1'b1;
                if (Start) begin
                    state_next = S_ARMED;
                    idx_next   = (ProgIdx == 2'd2) ? 2'd0 : ProgIdx + 2'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        PcTarget = P1_TARGET;
        unique case (ProgIdx)
            2'd1:    PcTarget = P2_TARGET;
            2'd2:    PcTarget = P3_TARGET;
            default: PcTarget = P1_TARGET;
        endcase
    end

`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_count_q;

    // Cleared on ARMED entry so a held Start does not keep restarting it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_count_q <= '0;
        end else if (state_next == S_ARMED && state != S_ARMED) begin
            cycle_count_q <= '0;
        end else if (state == S_RUN && cycle_count_q != '1) begin
            cycle_count_q <= cycle_count_q + 1'b1;
        end
    end

    assign CycleCount = cycle_count_q;
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed and randomized bench for program_sequencer
// Expected CycleCount follows PROGRAM_SEQUENCER_CYCLE_COUNT_EN.
module tb_program_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Halt;
    logic        PcLoad;
    logic [9:0]  PcTarget;
    logic        CoreEn;
    logic        Ack;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCount;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the controller is doing, as plain integers.
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;
    int m_phase = M_IDLE;
    int m_idx   = 0;
    int m_cnt   = 0;

`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 Clk = ~Clk;

    program_sequencer dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Halt(Halt),
        .PcLoad(PcLoad),
        .PcTarget(PcTarget),
        .CoreEn(CoreEn),
        .Ack(Ack),
        .ProgIdx(ProgIdx),
        .CycleCount(CycleCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_edge();
        if (Reset) begin
            m_phase = M_IDLE;
            m_idx   = 0;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (Start) begin m_phase = M_LOAD; m_cnt = 0; end
                M_LOAD: if (!Start) m_phase = M_RUN;
                M_RUN: begin
                    if (m_cnt < 65535) m_cnt++;
                    if (Halt) m_phase = M_DONE;
                end
                default: if (Start) begin
                    m_phase = M_LOAD;
                    m_idx   = (m_idx + 1) % 3;
                    m_cnt   = 0;
                end
            endcase
        end
    endfunction

    function automatic int exp_count();
        return CNT_EN ? m_cnt : 0;
    endfunction

    task automatic compare_all();
        check("pcload", 32'(PcLoad), 32'(m_phase == M_LOAD));
        check("coreen", 32'(CoreEn), 32'(m_phase == M_RUN));
        check("ack", 32'(Ack), 32'(m_phase == M_DONE));
        check("progidx", 32'(ProgIdx), 32'(m_idx));
        check("pctarget", 32'(PcTarget), 32'(m_idx * 256));
        check("cyclecount", 32'(CycleCount), 32'(exp_count()));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic launch();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
    endtask

    task automatic run_halt(input int n);
        Halt = 1'b0;
        repeat (n) tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    int exp_targets[3] = '{256, 512, 0};
    int load_cycles;
    int core_cycles;
    logic [15:0] held_count;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_cnt", 32'(CycleCount), 32'd0);

        // Single-cycle Start, Halt 20 cycles after RUN begins.
        Start = 1'b1;
        tick();
        check("first_load", 32'(PcLoad), 32'd1);
        check("first_target", 32'(PcTarget), 32'd0);
        Start = 1'b0;
        tick();
        check("one_armed_cycle", 32'(PcLoad), 32'd0);
        run_halt(20);
        check("halt_ack", 32'(Ack), 32'd1);
        check("halt_count", 32'(CycleCount), CNT_EN ? 32'd21 : 32'd0);

        // Three more rounds advance and wrap the program index.
        for (int r = 0; r < 3; r++) begin
            Start = 1'b1;
            tick();
            check("round_target", 32'(PcTarget), 32'(exp_targets[r]));
            Start = 1'b0;
            tick();
            run_halt(3 + r);
        end

        // Start held for five cycles.
        load_cycles = 0;
        core_cycles = 0;
        Start = 1'b1;
        repeat (5) begin
            tick();
            load_cycles += int'(PcLoad);
            core_cycles += int'(CoreEn);
        end
        check("held_load", 32'(load_cycles), 32'd5);
        check("held_core", 32'(core_cycles), 32'd0);
        Start = 1'b0;
        tick();
        check("held_run", 32'(CoreEn), 32'd1);

        // Start ignored in RUN; Halt wins over Start.
        Start = 1'b1;
        tick();
        tick();
        check("start_in_run", 32'(CoreEn), 32'd1);
        Halt = 1'b1;
        tick();
        Halt  = 1'b0;
        Start = 1'b0;
        check("halt_wins", 32'(Ack), 32'd1);
        check("halt_wins_idx", 32'(ProgIdx), 32'd1);

        // Reset mid-RUN of program 2.
        do_reset();
        launch();
        run_halt(2);
        launch();
        check("p2_running", 32'(ProgIdx), 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrun_ack", 32'(Ack), 32'd0);
        check("midrun_core", 32'(CoreEn), 32'd0);
        check("midrun_idx", 32'(ProgIdx), 32'd0);
        Start = 1'b1;
        tick();
        check("post_reset_target", 32'(PcTarget), 32'd0);
        Start = 1'b0;

        // Halt in IDLE, ARMED and DONE is ignored.
        do_reset();
        Halt = 1'b1;
        tick();
        check("halt_idle", 32'(Ack), 32'd0);
        Start = 1'b1;
        tick();
        tick();
        check("halt_armed", 32'(CoreEn), 32'd0);
        Start = 1'b0;
        Halt  = 1'b0;
        tick();
        run_halt(6);
        held_count = CycleCount;
        Halt = 1'b1;
        repeat (3) tick();
        Halt = 1'b0;
        check("halt_done_ack", 32'(Ack), 32'd1);
        check("halt_done_cnt", 32'(CycleCount), CNT_EN ? 32'd7 : 32'd0);
        check("halt_done_hold", 32'(CycleCount), 32'(held_count));

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 149) == 0);
            Start = ($urandom_range(0, 3) == 0);
            Halt  = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
